// File: rtl/mode7_pkg.sv
// mode7_pkg: shared config addresses, edge-mode encodings and reset coefficient for the Mode 7 renderer
package mode7_pkg;
  localparam logic [3:0] CFG_A    = 4'd0;
  localparam logic [3:0] CFG_B    = 4'd1;
  localparam logic [3:0] CFG_C    = 4'd2;
  localparam logic [3:0] CFG_D    = 4'd3;
  localparam logic [3:0] CFG_X0   = 4'd4;
  localparam logic [3:0] CFG_Y0   = 4'd5;
  localparam logic [3:0] CFG_HOFS = 4'd6;
  localparam logic [3:0] CFG_VOFS = 4'd7;
  localparam logic [3:0] CFG_MODE = 4'd8;
  typedef enum logic [1:0] {
    MODE_WRAP   = 2'd0,
    MODE_BORDER = 2'd1,
    MODE_CLAMP  = 2'd2
  } edge_mode_e;
  // Unit coefficient; shifted left by FRAC_W to form 1.0 in fixed point
  localparam logic [15:0] ONE_FX = 16'd1;
endpackage

// File: rtl/mode7_edge.sv
// mode7_edge: per-axis wrap/border/clamp mapping of an integer texture coordinate
module mode7_edge
  import mode7_pkg::*;
#(
  parameter int N = 6
) (
  input  logic signed [34:0] c,
  input  logic [1:0]         mode,
  output logic [N-1:0]       t,
  output logic               oob
);
  // Any set bit above the texture range (including the sign) means outside [0, 2^N-1]
  assign oob = |c[34:N];
  // Clamp saturates by sign; every other mode keeps the wrapped low bits
  assign t = (mode == MODE_CLAMP && oob) ? (c[34] ? '0 : '1) : c[N-1:0];
endmodule

// File: rtl/mode7_pipe.sv
// mode7_pipe: pipelined Mode 7 affine texture renderer with double-buffered config
module mode7_pipe
  import mode7_pkg::*;
#(
  parameter int TEX_W_LOG2 = 6,
  parameter int TEX_H_LOG2 = 6,
  parameter int COLOR_W = 8,
  parameter int COORD_W = 10,
  parameter int FRAC_W = 8,
  parameter logic [COLOR_W-1:0] BORDER_COLOR = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             p_tick,
  input  logic                             video_on,
  input  logic                             hsync_in,
  input  logic                             vsync_in,
  input  logic [COORD_W-1:0]               pixel_x,
  input  logic [COORD_W-1:0]               pixel_y,
  input  logic                             frame_start,
  input  logic                             cfg_we,
  input  logic [3:0]                       cfg_addr,
  input  logic [15:0]                      cfg_wdata,
  output logic [TEX_W_LOG2+TEX_H_LOG2-1:0] tex_addr,
  output logic                             tex_rd_en,
  input  logic [COLOR_W-1:0]               tex_data,
  output logic [COLOR_W-1:0]               rgb,
  output logic                             rgb_valid,
  output logic                             hsync_out,
  output logic                             vsync_out
);
  localparam logic [15:0] ONE = ONE_FX << FRAC_W;
  localparam logic [7:0][15:0] RST_BANK = {16'h0, 16'h0, 16'h0, 16'h0, ONE, 16'h0, 16'h0, ONE};

  logic [7:0][15:0] sh, act, sh_nxt;
  logic [1:0] sh_mode, act_mode, mode_nxt;
  logic signed [15:0] ca, cb, cc, cd, x0, y0, hofs, vofs;
  logic signed [17:0] s0_u, s0_v;
  logic signed [15:0] s0_a, s0_b, s0_c, s0_d, s0_x0, s0_y0, s1_x0, s1_y0;
  logic [1:0] s0_mode, s1_mode, s2_mode;
  logic signed [33:0] s1_pa, s1_pb, s1_pc, s1_pd;
  logic signed [34:0] sum_x, sum_y, s2_ix, s2_iy;
  logic [TEX_W_LOG2-1:0] tx;
  logic [TEX_H_LOG2-1:0] ty;
  logic oob_x, oob_y, s3_bord, rd_d;
  logic [3:0] vid_d, hs_d, vs_d;
  logic [COLOR_W-1:0] hold, texel;

  // Shadow bank with this clock's write applied; also what frame_start commits, so a coincident write lands in active
  always_comb begin
    sh_nxt = sh;
    if (cfg_we && !cfg_addr[3]) sh_nxt[cfg_addr[2:0]] = cfg_wdata;
    mode_nxt = (cfg_we && cfg_addr == CFG_MODE) ? cfg_wdata[1:0] : sh_mode;
  end

  // Shadow/active register banks
  always_ff @(posedge clk)
    if (reset) begin
      sh <= RST_BANK;
      act <= RST_BANK;
      sh_mode <= '0;
      act_mode <= '0;
    end else begin
      sh <= sh_nxt;
      sh_mode <= mode_nxt;
      if (frame_start) begin
        act <= sh_nxt;
        act_mode <= mode_nxt;
      end
    end

  assign ca = act[CFG_A[2:0]];
  assign cb = act[CFG_B[2:0]];
  assign cc = act[CFG_C[2:0]];
  assign cd = act[CFG_D[2:0]];
  assign x0 = act[CFG_X0[2:0]];
  assign y0 = act[CFG_Y0[2:0]];
  assign hofs = act[CFG_HOFS[2:0]];
  assign vofs = act[CFG_VOFS[2:0]];

  assign sum_x = 35'(s1_pa) + 35'(s1_pb) + (35'(s1_x0) <<< FRAC_W);
  assign sum_y = 35'(s1_pc) + 35'(s1_pd) + (35'(s1_y0) <<< FRAC_W);

  mode7_edge #(.N(TEX_W_LOG2)) u_edge_x (.c(s2_ix), .mode(s2_mode), .t(tx), .oob(oob_x));
  mode7_edge #(.N(TEX_H_LOG2)) u_edge_y (.c(s2_iy), .mode(s2_mode), .t(ty), .oob(oob_y));

  // Four-stage affine pipeline plus sync/video delay, advancing only on p_tick; each pixel carries its own parameters
  always_ff @(posedge clk)
    if (reset) begin
      s0_u <= '0;
      s0_v <= '0;
      {s0_a, s0_b, s0_c, s0_d, s0_x0, s0_y0, s0_mode} <= '0;
      {s1_pa, s1_pb, s1_pc, s1_pd, s1_x0, s1_y0, s1_mode} <= '0;
      {s2_ix, s2_iy, s2_mode} <= '0;
      tex_addr <= '0;
      s3_bord <= 1'b0;
      vid_d <= '0;
      hs_d <= '1;
      vs_d <= '1;
    end else if (p_tick) begin
      s0_u <= 18'(pixel_x) + 18'(hofs) - 18'(x0);
      s0_v <= 18'(pixel_y) + 18'(vofs) - 18'(y0);
      {s0_a, s0_b, s0_c, s0_d, s0_x0, s0_y0, s0_mode} <= {ca, cb, cc, cd, x0, y0, act_mode};
      s1_pa <= 34'(s0_a) * 34'(s0_u);
      s1_pb <= 34'(s0_b) * 34'(s0_v);
      s1_pc <= 34'(s0_c) * 34'(s0_u);
      s1_pd <= 34'(s0_d) * 34'(s0_v);
      {s1_x0, s1_y0, s1_mode} <= {s0_x0, s0_y0, s0_mode};
      s2_ix <= sum_x >>> FRAC_W;
      s2_iy <= sum_y >>> FRAC_W;
      s2_mode <= s1_mode;
      tex_addr <= {ty, tx};
      s3_bord <= s2_mode == MODE_BORDER && (oob_x || oob_y);
      vid_d <= {vid_d[2:0], video_on};
      hs_d <= {hs_d[2:0], hsync_in};
      vs_d <= {vs_d[2:0], vsync_in};
    end

  // Texture read strobe and hold register; tex_data is valid in the clock after tex_rd_en
  always_ff @(posedge clk)
    if (reset) begin
      tex_rd_en <= 1'b0;
      rd_d <= 1'b0;
      hold <= '0;
    end else begin
      tex_rd_en <= p_tick;
      rd_d <= tex_rd_en;
      if (rd_d) hold <= tex_data;
    end

  // Bypass covers a p_tick arriving in the same clock the texel is being captured
  assign texel = rd_d ? tex_data : hold;

  // Output stage: blank while video is off, border colour for out-of-range texels
  always_ff @(posedge clk)
    if (reset) begin
      rgb <= '0;
      rgb_valid <= 1'b0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else if (p_tick) begin
      rgb <= vid_d[3] ? (s3_bord ? BORDER_COLOR : texel) : '0;
      rgb_valid <= vid_d[3];
      hsync_out <= hs_d[3];
      vsync_out <= vs_d[3];
    end
endmodule

// File: doc/mode7_pipe.md
# mode7_pipe

Parametrised, pipelined Mode 7 affine renderer. Sits between `vga_sync` and the RGB output register. It maps each screen pixel through a programmable 2×2 matrix with origin and scroll offsets into texture space and fetches a texel from an external synchronous texture RAM. Matrix/scroll parameters are double-buffered and committed at frame start. The block adds wrap/border/clamp edge modes and keeps sync signals aligned with pixel data.

## Interface

**Parameters**
- `TEX_W_LOG2`, 6: texture width is 2^TEX_W_LOG2.
- `TEX_H_LOG2`, 6: texture height is 2^TEX_H_LOG2.
- `COLOR_W`, 8: texel/RGB width.
- `COORD_W`, 10: screen coordinate width.
- `FRAC_W`, 8: fractional bits of the matrix coefficients (signed 8.8 at default).
- `BORDER_COLOR`, 0: colour for out-of-range texels in border mode.

**Ports**
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `p_tick` in 1: pixel enable. Consecutive pulses are at least 2 clk apart.
- `video_on` in 1: active-video flag from `vga_sync`.
- `hsync_in`, `vsync_in` in 1 each: syncs from `vga_sync` (active-low).
- `pixel_x`, `pixel_y` in COORD_W each: current pixel.
- `frame_start` in 1: one-clk pulse; commits shadow registers.
- `cfg_we` in 1: config write strobe.
- `cfg_addr` in 4: config register select.
- `cfg_wdata` in 16: config write data.
- `tex_addr` out TEX_W_LOG2+TEX_H_LOG2: texel address `{ty, tx}`.
- `tex_rd_en` out 1: read strobe.
- `tex_data` in COLOR_W: texel, valid exactly 1 clk after `tex_rd_en`.
- `rgb` out COLOR_W: pixel colour.
- `rgb_valid` out 1: delayed `video_on`.
- `hsync_out`, `vsync_out` out 1 each: syncs aligned to `rgb`.

## Operation

**Config registers** (shadow bank written by `cfg_we`, active bank used for rendering):
- Addresses: 0 `A`, 1 `B`, 2 `C`, 3 `D` (signed 16-bit, FRAC_W fractional bits); 4 `X0`; 5 `Y0`; 6 `HOFS`; 7 `VOFS` (signed 16-bit integers); 8 `MODE` (bits [1:0]).
- Writes to addresses 9–15 are ignored.
- Reset value in both banks: `A=D=1<<FRAC_W`, all others 0, `MODE=0`.
- On `frame_start`, active ← shadow. A write in the same clk is forwarded, so the new value lands in active.

**Per pixel** (all arithmetic signed, no saturation):
- `u = pixel_x + HOFS − X0`, `v = pixel_y + VOFS − Y0`.
- `TX = A·u + B·v + (X0<<FRAC_W)`, `TY = C·u + D·v + (Y0<<FRAC_W)`.
- Operands are sign-extended to 18 bits, products to 34 bits, sums to 35 bits.
- Integer coordinates: `ix = TX>>>FRAC_W`, `iy = TY>>>FRAC_W` (arithmetic shift, floor toward −∞).

**Edge modes** (`MODE`):
- 0 wrap: `tx = ix[TEX_W_LOG2-1:0]`, `ty` likewise.
- 1 border: if either coordinate is outside [0, 2^N−1], output `BORDER_COLOR`. The texture read still issues at the wrapped address.
- 2 clamp: each coordinate is saturated to [0, 2^N−1].
- 3: treated as 0.

**Output**
- While the delayed `video_on` is 0, `rgb = 0` regardless of the texel.

## Timing

**Pipeline** advances only on `p_tick`, over 4 stages:
- S0: capture `u`, `v`, `video_on`, syncs.
- S1: four products.
- S2: sums and shift.
- S3: edge mode; drive `tex_addr` and pulse `tex_rd_en` for 1 clk on the advancing `p_tick`.
- `tex_data` is registered 1 clk later into a hold register.
- The next `p_tick` moves the hold register to `rgb`.

**Latency**
- Pixel sampled on `p_tick` n appears on `rgb`/`rgb_valid`/syncs 1 clk after `p_tick` n+4.
- Syncs and `video_on` pass through an identical 5-deep delay.

**Reset**
- `rgb=0`, `rgb_valid=0`, `hsync_out=vsync_out=1`, `tex_rd_en=0`, `tex_addr=0`.
- All pipeline stages are cleared. Reset mid-frame discards in-flight pixels.

**Parameter changes**
- Active parameters change only on `frame_start`. Pixels already in the pipeline keep the values sampled at S0.

## Structure

**Shared package `mode7_pkg`**
- Config address constants: `CFG_A` through `CFG_MODE`.
- Mode encodings: `MODE_WRAP`, `MODE_BORDER`, `MODE_CLAMP`.
- Reset coefficient `ONE_FX`.

**Sub-module `mode7_edge`**
- Combinational per-axis wrap/border/clamp.
- Inputs: 35-bit integer coordinate, mode.
- Outputs: N-bit coordinate, out-of-range flag.
- Instantiated twice.

Register bank and pipeline stay in `mode7_pipe`.

## Test plan

- **Identity matrix, mode 0, texture = address LSBs:** pixel (5,3) → `tex_addr={6'd3,6'd5}`, `rgb=tex[3][5]` 1 clk after the 4th subsequent `p_tick`.
- **Wrap vs clamp:** `HOFS=70`, pixel (0,0).
  - Mode 0: tx=6.
  - Mode 2: tx=63.
  - Mode 1: `rgb=BORDER_COLOR`.
- **Negative coordinate:** `HOFS=−1`, pixel (0,0).
  - Mode 0: tx=63.
  - Mode 2: tx=0.
- **Scale 2× (`A=D=0x0080`):** pixels x=0..3 map to tx 0,0,1,1.
- **Shadow commit:** write `A=0x0200` mid-frame.
  - Current-frame output is unchanged.
  - After `frame_start`, x=3 maps to tx=6.
  - A write coincident with `frame_start` takes effect immediately.
- **Blanking and reset:** `video_on=0` → `rgb=0`, `rgb_valid=0`, sync delay checked. Asserting `reset` mid-line → all outputs at reset values next clk; the first valid pixel appears 4 `p_tick`s after release.
